// File: rtl/fm_demod_pkg.sv
// rtl/fm_demod_pkg.sv - shared widths, phase encoding and saturation bounds for the FM demod path
package fm_demod_pkg;

    localparam int IN_W_DEF         = 16;
    localparam int OUT_W_DEF        = 16;
    localparam int OUT_SHIFT_DEF    = 15;
    localparam int DEEMPH_SHIFT_DEF = 4;

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } phase_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/fm_discriminator_if.sv
// rtl/fm_discriminator_if.sv - sample-in / demodulated-out bundle for fm_discriminator
interface fm_discriminator_if
    import fm_demod_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic signed [IN_W-1:0]  data_i;
    logic                    valid_i;
    logic                    align_i;
    logic signed [OUT_W-1:0] data_o;
    logic                    valid_o;
    logic                    sat_o;

    modport slave  (input  data_i, valid_i, align_i, output data_o, valid_o, sat_o);
    modport master (output data_i, valid_i, align_i, input  data_o, valid_o, sat_o);
endinterface

// File: rtl/fm_shift_sat.sv
// rtl/fm_shift_sat.sv - floor arithmetic right shift followed by saturation to OUT_W signed
module fm_shift_sat
    import fm_demod_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = OUT_SHIFT_DEF
) (
    input  logic signed [IN_W-1:0]  i_value,
    output logic signed [OUT_W-1:0] o_value,
    output logic                    o_clip
);
    localparam logic signed [IN_W-1:0] L_MAX = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] L_MIN = IN_W'(sat_min(OUT_W));

    logic signed [IN_W-1:0] w_shifted;
    logic                   w_hi;
    logic                   w_lo;

    assign w_shifted = i_value >>> SHIFT;
    assign w_hi      = (w_shifted > L_MAX);
    assign w_lo      = (w_shifted < L_MIN);
    assign o_clip    = w_hi | w_lo;
    assign o_value   = w_hi ? L_MAX[OUT_W-1:0] :
                       w_lo ? L_MIN[OUT_W-1:0] : w_shifted[OUT_W-1:0];
endmodule

// File: rtl/fm_discriminator.sv
// rtl/fm_discriminator.sv - cross-product FM discriminator on interleaved I/Q samples
// Optional single-pole de-emphasis stage enabled by defining FM_DEEMPH_EN.
module fm_discriminator
    import fm_demod_pkg::*;
#(
    parameter int IN_W         = IN_W_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int OUT_SHIFT    = OUT_SHIFT_DEF,
    parameter int DEEMPH_SHIFT = DEEMPH_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fm_discriminator_if.slave  bus
);
    localparam int P_W = 2 * IN_W;
    localparam int D_W = P_W + 1;

    phase_t r_phase;
    phase_t w_phase_next;
    logic   w_take_i;
    logic   w_pair_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_phase <= WAIT_I;
        else     r_phase <= w_phase_next;
    end

    // align_i wins over the current phase and drops any half-received pair
    always_comb begin
        w_phase_next = r_phase;
        w_take_i     = 1'b0;
        w_pair_done  = 1'b0;
        if (bus.align_i) begin
            w_phase_next = bus.valid_i ? WAIT_Q : WAIT_I;
            w_take_i     = bus.valid_i;
        end else if (bus.valid_i) begin
            case (r_phase)
                WAIT_I: begin
                    w_take_i     = 1'b1;
                    w_phase_next = WAIT_Q;
                end
                WAIT_Q: begin
                    w_pair_done  = 1'b1;
                    w_phase_next = WAIT_I;
                end
                default: w_phase_next = WAIT_I;
            endcase
        end
    end

    logic signed [IN_W-1:0] r_i;
    logic signed [IN_W-1:0] r_i_prev;
    logic signed [IN_W-1:0] r_q_prev;
    logic                   r_primed;
    logic signed [P_W-1:0]  r_p1;
    logic signed [P_W-1:0]  r_p2;
    logic                   r_s1_valid;

    logic signed [P_W-1:0]  w_i_ext;
    logic signed [P_W-1:0]  w_q_ext;
    logic signed [P_W-1:0]  w_i_prev_ext;
    logic signed [P_W-1:0]  w_q_prev_ext;

    assign w_i_ext      = {{IN_W{r_i[IN_W-1]}}, r_i};
    assign w_q_ext      = {{IN_W{bus.data_i[IN_W-1]}}, bus.data_i};
    assign w_i_prev_ext = {{IN_W{r_i_prev[IN_W-1]}}, r_i_prev};
    assign w_q_prev_ext = {{IN_W{r_q_prev[IN_W-1]}}, r_q_prev};

    // The first pair after reset only seeds the history; no product is formed from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i        <= '0;
            r_i_prev   <= '0;
            r_q_prev   <= '0;
            r_primed   <= 1'b0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_pair_done & r_primed;
            if (w_take_i) r_i <= bus.data_i;
            if (w_pair_done) begin
                r_i_prev <= r_i;
                r_q_prev <= bus.data_i;
                r_primed <= 1'b1;
                if (r_primed) begin
                    r_p1 <= w_i_prev_ext * w_q_ext;
                    r_p2 <= w_q_prev_ext * w_i_ext;
                end
            end
        end
    end

    logic signed [D_W-1:0]   w_d;
    logic signed [OUT_W-1:0] w_sat_value;
    logic                    w_clip;

    assign w_d = {r_p1[P_W-1], r_p1} - {r_p2[P_W-1], r_p2};

    fm_shift_sat #(
        .IN_W  (D_W),
        .OUT_W (OUT_W),
        .SHIFT (OUT_SHIFT)
    ) u_shift_sat (
        .i_value (w_d),
        .o_value (w_sat_value),
        .o_clip  (w_clip)
    );

    logic signed [OUT_W-1:0] r_s2_data;
    logic                    r_s2_valid;
    logic                    r_s2_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sat   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sat   <= r_s1_valid & w_clip;
            if (r_s1_valid) r_s2_data <= w_sat_value;
        end
    end

`ifdef FM_DEEMPH_EN
    logic signed [OUT_W-1:0] r_s;
    logic                    r_d_valid;
    logic                    r_d_sat;
    logic signed [OUT_W:0]   w_diff;
    logic signed [OUT_W:0]   w_step;

    // s stays between its old value and x, so the add cannot overflow OUT_W
    assign w_diff = {r_s2_data[OUT_W-1], r_s2_data} - {r_s[OUT_W-1], r_s};
    assign w_step = w_diff >>> DEEMPH_SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s       <= '0;
            r_d_valid <= 1'b0;
            r_d_sat   <= 1'b0;
        end else begin
            r_d_valid <= r_s2_valid;
            r_d_sat   <= r_s2_sat;
            if (r_s2_valid) r_s <= r_s + OUT_W'(w_step);
        end
    end

    assign bus.data_o  = r_s;
    assign bus.valid_o = r_d_valid;
    assign bus.sat_o   = r_d_sat;
`else
    assign bus.data_o  = r_s2_data;
    assign bus.valid_o = r_s2_valid;
    assign bus.sat_o   = r_s2_sat;
`endif

endmodule

// File: tb/tb_fm_discriminator.sv
// tb/tb_fm_discriminator.sv - scoreboard bench for fm_discriminator with directed I/Q pairs
module tb_fm_discriminator;

`ifdef FM_DEEMPH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic signed [15:0] data;
        logic               sat;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   s_model = 0;
    exp_t sb[$];

    fm_discriminator_if bus ();

    fm_discriminator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int shape(input int raw);
`ifdef FM_DEEMPH_EN
        s_model = s_model + ((raw - s_model) >>> 4);
        return s_model;
`else
        return raw;
`endif
    endfunction

    task automatic drv(input logic signed [15:0] d, input logic v, input logic a);
        @(negedge clk);
        bus.data_i  = d;
        bus.valid_i = v;
        bus.align_i = a;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(16'sd0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input int raw, input logic sat);
        exp_t e;
        e.data = 16'(shape(raw));
        e.sat  = sat;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic pair(input logic signed [15:0] i, input logic signed [15:0] q,
                        input bit emit, input int raw, input logic sat);
        drv(i, 1'b1, 1'b0);
        drv(q, 1'b1, 1'b0);
        if (emit) expect_out(raw, sat);
    endtask

    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %0d with no expected output (cycle %0d)",
                         bus.data_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_o", bus.data_o, e.data);
                chk("sat_o", bus.sat_o, e.sat);
                chk("latency_cycle", cyc, e.cyc);
            end
        end else if (bus.sat_o) begin
            checks++;
            errors++;
            $display("FAIL sat_without_valid: got sat_o 1 expected 0 (cycle %0d)", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [15:0] ph_i [4];
        logic signed [15:0] ph_q [4];
        ph_i[0] = 16'sd1000;  ph_q[0] = 16'sd0;
        ph_i[1] = 16'sd0;     ph_q[1] = 16'sd1000;
        ph_i[2] = -16'sd1000; ph_q[2] = 16'sd0;
        ph_i[3] = 16'sd0;     ph_q[3] = -16'sd1000;

        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.align_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_o", bus.data_o, 0);
        chk("reset_valid_o", bus.valid_o, 0);
        chk("reset_sat_o", bus.sat_o, 0);
        rst = 1'b0;

        // priming pair then positive rotation
        pair(16'sd1000, 16'sd0, 1'b0, 0, 1'b0);
        pair(16'sd0, 16'sd1000, 1'b1, 30, 1'b0);
        // repeat of same pair, then negative rotation (floor)
        pair(16'sd0, 16'sd1000, 1'b1, 0, 1'b0);
        pair(16'sd1000, 16'sd0, 1'b1, -31, 1'b0);
        // full-scale products: exact -1000, then clip high and clip low
        pair(16'sd32767, -16'sd32768, 1'b1, -1000, 1'b0);
        pair(16'sd32767, 16'sd32767, 1'b1, 32767, 1'b1);
        pair(16'sd32767, -16'sd32768, 1'b1, -32768, 1'b1);
        idle(2);

        // stray I discarded by align with valid
        drv(16'sd5000, 1'b1, 1'b0);
        drv(16'sd0, 1'b1, 1'b1);
        drv(16'sd1000, 1'b1, 1'b0);
        expect_out(999, 1'b0);
        // align on an idle cycle: next valid sample is I
        drv(16'sd7, 1'b1, 1'b0);
        drv(16'sd0, 1'b0, 1'b1);
        pair(16'sd1000, 16'sd0, 1'b1, -31, 1'b0);
        // gaps inside a pair do not advance the phase
        drv(16'sd0, 1'b1, 1'b0);
        idle(3);
        drv(16'sd1000, 1'b1, 1'b0);
        expect_out(30, 1'b0);
        idle(6);
        chk("drained_before_reset", sb.size(), 0);

        pair(16'sd1000, 16'sd0, 1'b1, -31, 1'b0);
        pair(16'sd0, 16'sd1000, 1'b1, 30, 1'b0);
        idle(5);
        drv(-16'sd1000, 1'b1, 1'b0);
        drv(16'sd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        s_model = 0;
        #1;
        chk("midpair_reset_data_o", bus.data_o, 0);
        chk("midpair_reset_valid_o", bus.valid_o, 0);
        chk("midpair_reset_sat_o", bus.sat_o, 0);
        @(negedge clk);
        rst = 1'b0;
        pair(16'sd1000, 16'sd0, 1'b0, 0, 1'b0);
        pair(16'sd0, 16'sd1000, 1'b1, 30, 1'b0);

        // constant rotation (raw 30) with random gaps
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (k + 2) % 4;
            idle($urandom_range(0, 2));
            drv(ph_i[idx], 1'b1, 1'b0);
            idle($urandom_range(0, 2));
            drv(ph_q[idx], 1'b1, 1'b0);
            expect_out(30, 1'b0);
        end

        idle(8);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
